// File: rtl/serial_word_feeder_if.sv
// Word handshake between a word producer and the serial_word_feeder.
// The producer drives data_i/valid_i; the feeder answers with ready_o.
interface serial_word_feeder_if #(
   parameter int WIDTH = 36
);
   logic [WIDTH-1:0] data_i;
   logic             valid_i;
   logic             ready_o;

   // Word producer side
   modport master (
      output data_i,
      output valid_i,
      input  ready_o
   );

   // Feeder side
   modport slave (
      input  data_i,
      input  valid_i,
      output ready_o
   );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for the bit-serial sequence detector.
// Words arrive over a valid/ready handshake into a one-word pending buffer,
// move into the shifter when it is free, and leave one bit per clock on x_o.
// The pending buffer refills while a word is shifting, so consecutive words
// stream without an idle cycle. stall_i freezes shifter and bit counter
// without dropping a bit.
module serial_word_feeder #(
   parameter int WIDTH     = 36,   // bits per word, WIDTH >= 2
   parameter bit MSB_FIRST = 1'b1, // 1: bit WIDTH-1 leaves first
   parameter int CNT_W     = 16    // width of the sent-word counter
) (
   input  logic                 clk,
   input  logic                 reset,        // async, active low
   serial_word_feeder_if.slave  bus,
   input  logic                 stall_i,
   output logic                 x_o,
   output logic                 x_valid_o,
   output logic                 sow_o,
   output logic                 eow_o,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     words_sent_o
);

   // Bit counter must hold WIDTH itself (a freshly loaded word).
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t              state_r,      state_n;
   logic [WIDTH-1:0]    sh_r,         sh_n;
   logic [CW-1:0]       cnt_r,        cnt_n;
   logic [WIDTH-1:0]    pend_r,       pend_n;
   logic                pend_valid_r, pend_valid_n;
   logic [CNT_W-1:0]    words_r,      words_n;

   logic                accept_s;
   logic                last_bit_s;
   logic                move_s;

   // Advance the shifter one place toward the output end, zero-filling
   // the vacated end so no stale or unknown bit ever reaches x_o.
   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] r;
      if (MSB_FIRST) begin
         r = {w[WIDTH-2:0], 1'b0};
      end else begin
         r = {1'b0, w[WIDTH-1:1]};
      end
      return r;
   endfunction

   // The bit currently presented at the output end of the shifter.
   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      logic b;
      if (MSB_FIRST) begin
         b = w[WIDTH-1];
      end else begin
         b = w[0];
      end
      return b;
   endfunction

   // ready depends on registered state only, so there is no path from valid.
   assign bus.ready_o  = !pend_valid_r;
   assign accept_s     = bus.valid_i && !pend_valid_r;
   assign last_bit_s   = (state_r == SHIFT) && !stall_i && (cnt_r == CNT_ONE);
   // The pending word moves into the shifter only while the buffer is full,
   // and a new word is accepted only while it is empty: the two never meet.
   assign move_s       = pend_valid_r && ((state_r == IDLE) || last_bit_s);
   assign words_sent_o = words_r;

   // State, shifter, bit counter and sent-word counter next-state logic.
   always_comb begin
      state_n = state_r;
      sh_n    = sh_r;
      cnt_n   = cnt_r;
      words_n = words_r;
      case (state_r)
         IDLE: begin
            if (pend_valid_r) begin
               sh_n    = pend_r;
               cnt_n   = CNT_FULL;
               state_n = SHIFT;
            end else begin
               sh_n    = {WIDTH{1'b0}};
               cnt_n   = CNT_ZERO;
               state_n = IDLE;
            end
         end
         SHIFT: begin
            if (stall_i) begin
               state_n = SHIFT;
            end else if (cnt_r == CNT_ONE) begin
               words_n = words_r + CNT_W'(1);
               if (pend_valid_r) begin
                  // Reload immediately so the next word follows with no gap.
                  sh_n    = pend_r;
                  cnt_n   = CNT_FULL;
                  state_n = SHIFT;
               end else begin
                  sh_n    = {WIDTH{1'b0}};
                  cnt_n   = CNT_ZERO;
                  state_n = IDLE;
               end
            end else begin
               sh_n    = shift_word(sh_r);
               cnt_n   = cnt_r - CNT_ONE;
               state_n = SHIFT;
            end
         end
         default: begin
            sh_n    = {WIDTH{1'b0}};
            cnt_n   = CNT_ZERO;
            state_n = IDLE;
         end
      endcase
   end

   // Pending buffer: fill on a handshake, empty when its word moves on.
   always_comb begin
      pend_n       = pend_r;
      pend_valid_n = pend_valid_r;
      if (accept_s) begin
         pend_n       = bus.data_i;
         pend_valid_n = 1'b1;
      end else if (move_s) begin
         pend_valid_n = 1'b0;
      end else begin
         pend_valid_n = pend_valid_r;
      end
   end

   // State registers; reset drops any in-flight and pending word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         sh_r         <= {WIDTH{1'b0}};
         cnt_r        <= CNT_ZERO;
         pend_r       <= {WIDTH{1'b0}};
         pend_valid_r <= 1'b0;
         words_r      <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_n;
         sh_r         <= sh_n;
         cnt_r        <= cnt_n;
         pend_r       <= pend_n;
         pend_valid_r <= pend_valid_n;
         words_r      <= words_n;
      end
   end

   // Serial outputs decoded from registered state; a stall only masks valid,
   // the presented bit is held so the detector sees it again once released.
   always_comb begin
      x_valid_o = 1'b0;
      x_o       = 1'b0;
      if (state_r == SHIFT) begin
         x_valid_o = !stall_i;
         x_o       = out_bit(sh_r);
      end else begin
         x_valid_o = 1'b0;
         x_o       = 1'b0;
      end
      sow_o  = x_valid_o && (cnt_r == CNT_FULL);
      eow_o  = x_valid_o && (cnt_r == CNT_ONE);
      busy_o = (state_r == SHIFT) || pend_valid_r;
   end

endmodule
